// File: rtl/gray_sweep_ctrl.sv
// gray_sweep_ctrl: walks the 4-bit drive vector of the binary-to-Gray converter
// through all 16 codes, holds each one for SETTLE cycles, then checks the
// converter output against the expected Gray code. It counts mismatches,
// records the first failing code and reports pass/fail with a one-cycle DONE.
// Optional build macro GSC_STEP_EN: adds the STEP input and a HOLD state so
// the sweep advances to the next code only on a STEP request.
module gray_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ABORT,
  input  logic [3:0] G_IN,
  output logic [3:0] VEC_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [4:0] ERR_CNT,
  output logic       FIRST_ERR_VALID,
  output logic [3:0] FIRST_ERR_VEC
`ifdef GSC_STEP_EN
  ,
  input  logic       STEP
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_HOLD,
    S_FINISH
  } state_t;

  // Counter value on the last settle cycle; SETTLE is 1..15 so this fits 4 bits.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       mismatch;
  logic [4:0] err_nxt;

  // Reflected binary code of the drive vector.
  function automatic logic [3:0] gray_of(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Mismatch counter step; holds at 16 so the 5-bit count can never wrap.
  function automatic logic [4:0] err_inc(input logic [4:0] c, input logic hit);
    if (hit && (c != 5'd16)) return c + 5'd1;
    return c;
  endfunction

  assign mismatch = (G_IN != gray_of(VEC_OUT));
  assign err_nxt  = err_inc(ERR_CNT, mismatch);

  // Sweep sequencer: state, drive vector, settle counter and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= S_IDLE;
      cnt             <= 4'd0;
      VEC_OUT         <= 4'd0;
      BUSY            <= 1'b0;
      DONE            <= 1'b0;
      PASS            <= 1'b0;
      ERR_CNT         <= 5'd0;
      FIRST_ERR_VALID <= 1'b0;
      FIRST_ERR_VEC   <= 4'd0;
    end else if (ABORT && (state != S_IDLE)) begin
      // Cancel: error count and first-error record stay frozen for inspection.
      state   <= S_IDLE;
      cnt     <= 4'd0;
      VEC_OUT <= 4'd0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      PASS    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (START && !ABORT) begin
            state           <= S_SETTLE;
            cnt             <= 4'd0;
            VEC_OUT         <= 4'd0;
            BUSY            <= 1'b1;
            PASS            <= 1'b0;
            ERR_CNT         <= 5'd0;
            FIRST_ERR_VALID <= 1'b0;
            FIRST_ERR_VEC   <= 4'd0;
          end
        end

        S_SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == SETTLE_LAST) state <= S_CHECK;
        end

        S_CHECK: begin
          ERR_CNT <= err_nxt;
          if (mismatch && !FIRST_ERR_VALID) begin
            FIRST_ERR_VALID <= 1'b1;
            FIRST_ERR_VEC   <= VEC_OUT;
          end
          if (VEC_OUT == 4'd15) begin
            // Last code: the final check's result is folded into PASS.
            state <= S_FINISH;
            DONE  <= 1'b1;
            PASS  <= (err_nxt == 5'd0);
          end else begin
`ifdef GSC_STEP_EN
            state <= S_HOLD;
`else
            VEC_OUT <= VEC_OUT + 4'd1;
            cnt     <= 4'd0;
            state   <= S_SETTLE;
`endif
          end
        end

`ifdef GSC_STEP_EN
        S_HOLD: begin
          if (STEP) begin
            VEC_OUT <= VEC_OUT + 4'd1;
            cnt     <= 4'd0;
            state   <= S_SETTLE;
          end
        end
`endif

        S_FINISH: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
